adder_pipe_nbit: RTL and testbench



---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_nbit.sv | 41 ++++
 rtl/adder_pipe_nbit.sv | 99 +++++++++
 tb/tb_adder_pipe_nbit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and the stage-register layout for the pipelined adder.
// The top module mirrors stage_t at its own WIDTH.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_CHUNK = 4;

  typedef struct packed {
    logic                   valid;
    logic [ADDER_WIDTH-1:0] a_hi;
    logic [ADDER_WIDTH-1:0] b_hi;
    logic [ADDER_WIDTH-1:0] sum_lo;
    logic                   carry;
    logic                   a_msb;
    logic                   b_msb;
  } stage_t;

endpackage

// File: rtl/adder_nbit.sv
// Combinational N-bit ripple adder built from a chain of full adders.
// One instance handles one pipeline chunk.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] c;

  assign c[0]      = carry_in;
  assign carry_out = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    adder_1bit u_fa (
      .a        (a[i]),
      .b        (b[i]),
      .carry_in (c[i]),
      .sum      (sum[i]),
      .carry_out(c[i+1])
    );
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder, CHUNK bits per stage, registered carry chain.
// The whole pipe advances as one unit under a single valid/ready stall.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_pipe_nbit: WIDTH must be a multiple of CHUNK");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
  } pipe_t;

  pipe_t            src    [STAGES];
  pipe_t            pipe_d [STAGES];
  pipe_t            pipe_q [STAGES];
  logic [CHUNK-1:0] part   [STAGES];
  logic             cout   [STAGES];
  logic             adv;

  assign adv      = !pipe_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;

  // Stage 0 sees the ports; every later stage sees its predecessor.
  always_comb begin
    src[0]        = '0;
    src[0].valid  = in_valid;
    src[0].a_hi   = a;
    src[0].b_hi   = b;
    src[0].carry  = carry_in;
    src[0].a_msb  = a[WIDTH-1];
    src[0].b_msb  = b[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      src[k] = pipe_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_nbit #(.N(CHUNK)) u_add (
      .a        (src[k].a_hi[k*CHUNK +: CHUNK]),
      .b        (src[k].b_hi[k*CHUNK +: CHUNK]),
      .carry_in (src[k].carry),
      .sum      (part[k]),
      .carry_out(cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      pipe_d[k]                          = src[k];
      pipe_d[k].sum_lo[k*CHUNK +: CHUNK] = part[k];
      pipe_d[k].carry                    = cout[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign sum       = pipe_q[STAGES-1].sum_lo;
  assign carry_out = pipe_q[STAGES-1].carry;
  assign overflow  = (pipe_q[STAGES-1].a_msb == pipe_q[STAGES-1].b_msb) &&
                     (pipe_q[STAGES-1].sum_lo[WIDTH-1] != pipe_q[STAGES-1].a_msb);

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed tests on the 16/4 instance plus
// queue scoreboards on four parameterisations sharing one stimulus bus.
module tb_adder_pipe_nbit;

  localparam int NI = 4;
  localparam int WS [NI] = '{16, 8, 32, 12};
  localparam int CS [NI] = '{4, 8, 4, 3};

  typedef struct {
    logic [33:0] exp;
    int          cyc;
    int          stl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic c);
    logic [32:0] full;
    logic [31:0] m;
    logic [31:0] s;
    logic        co;
    logic        ov;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    s    = full[31:0] & m;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int C = CS[g];
    localparam int S = W / C;
    logic         in_ready;
    logic         out_valid;
    logic         carry_out;
    logic         overflow;
    logic [W-1:0] sum;
    ent_t         q[$];
    int           stl = 0;

    adder_pipe_nbit #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a_s[W-1:0]),
      .b        (b_s[W-1:0]),
      .carry_in (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .carry_out(carry_out),
      .overflow (overflow)
    );

    initial begin : mon
      ent_t        e;
      logic [31:0] sx;
      logic [33:0] got;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
        end else begin
          if (out_valid && out_ready) begin
            sx        = '0;
            sx[W-1:0] = sum;
            got       = {overflow, carry_out, sx};
            n_cmp++;
            if (q.size() == 0) begin
              n_bad++;
              $display("FAIL sb_spurious W=%0d C=%0d: got result %h, required none pending", W, C, got);
            end else begin
              e = q.pop_front();
              if (got !== e.exp) begin
                n_bad++;
                $display("FAIL sb_result W=%0d C=%0d: got %h, required %h", W, C, got, e.exp);
              end
              n_cmp++;
              if ((cyc - e.cyc) !== (S + stl - e.stl)) begin
                n_bad++;
                $display("FAIL sb_latency W=%0d C=%0d: got %0d, required %0d",
                         W, C, cyc - e.cyc, S + stl - e.stl);
              end
            end
          end
          if (in_valid && in_ready) begin
            e.exp = model(W, a_s, b_s, cin);
            e.cyc = cyc;
            e.stl = stl;
            q.push_back(e);
          end
          if (out_valid && !out_ready) stl++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [33:0] got16();
    return {g_dut[0].overflow, g_dut[0].carry_out, 16'h0, g_dut[0].sum};
  endfunction

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (g_dut[0].out_valid !== 1'b0 || got16() !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b %h, required v=0 0", g_dut[0].out_valid, got16());
    end
    n_cmp++;
    if (g_dut[0].in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 1", g_dut[0].in_ready);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      a_s = $urandom | 32'h0000_8001;
      b_s = $urandom;
      cin = 1'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (g_dut[0].out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_prefill: got out_valid %b, required 1", g_dut[0].out_valid);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (g_dut[0].out_valid !== 1'b0 || got16() !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b %h, required v=0 0", g_dut[0].out_valid, got16());
    end
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (g_dut[0].in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b, required 1", g_dut[0].in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (g_dut[0].out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL reset_stale: got %0d valid cycles, required 0", seen);
    end
  endtask

  task automatic test_single();
    idle(2);
    a_s = 32'h1234;
    b_s = 32'h4321;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      n_cmp++;
      if (g_dut[0].out_valid !== (i == 4)) begin
        n_bad++;
        $display("FAIL single_valid c%0d: got %b, required %b", i, g_dut[0].out_valid, i == 4);
      end
      if (i == 4) begin
        n_cmp++;
        if (got16() !== {2'b00, 32'h0000_5556}) begin
          n_bad++;
          $display("FAIL single_value: got %h, required %h", got16(), {2'b00, 32'h5556});
        end
      end
    end
  endtask

  task automatic test_carry();
    idle(2);
    a_s = 32'hFFFF;
    b_s = 32'h0000;
    cin = 1'b1;
    in_valid = 1'b1;
    step();
    a_s = 32'h7FFF;
    b_s = 32'h0001;
    cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (g_dut[0].out_valid !== 1'b1 || got16() !== {2'b01, 32'h0000_0000}) begin
      n_bad++;
      $display("FAIL carry_ripple: got v=%b %h, required v=1 %h",
               g_dut[0].out_valid, got16(), {2'b01, 32'h0});
    end
    step();
    n_cmp++;
    if (g_dut[0].out_valid !== 1'b1 || got16() !== {2'b10, 32'h0000_8000}) begin
      n_bad++;
      $display("FAIL carry_overflow: got v=%b %h, required v=1 %h",
               g_dut[0].out_valid, got16(), {2'b10, 32'h8000});
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exq[$];
    logic [33:0] e;
    idle(3);
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        a_s = 32'(16'(k - 1) * 16'h1111);
        b_s = 32'hF0F0;
        cin = 1'((k - 1) & 1);
        in_valid = 1'b1;
        exq.push_back(model(16, a_s, b_s, cin));
      end else begin
        in_valid = 1'b0;
      end
      step();
      n_cmp++;
      if (g_dut[0].out_valid !== (k >= 4 && k <= 11)) begin
        n_bad++;
        $display("FAIL b2b_valid c%0d: got %b, required %b", k, g_dut[0].out_valid, k >= 4 && k <= 11);
      end
      if (k >= 4 && k <= 11 && exq.size() > 0) begin
        e = exq.pop_front();
        n_cmp++;
        if (got16() !== e) begin
          n_bad++;
          $display("FAIL b2b_value c%0d: got %h, required %h", k, got16(), e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exq[$];
    logic [33:0] held;
    logic [33:0] e;
    logic [31:0] oa [10];
    logic [31:0] ob [10];
    logic        oc [10];
    int          j = 0;
    int          ret = 0;
    int          stall_left = 0;
    bit          stalled = 0;
    bit          was_stall = 0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      oa[i] = $urandom;
      ob[i] = $urandom;
      oc[i] = 1'($urandom_range(1));
    end
    idle(3);
    for (int t = 0; t < 60 && ret < 10; t++) begin
      if (!stalled && g_dut[0].out_valid) begin
        stalled = 1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid = (j < 10);
      if (j < 10) begin
        a_s = oa[j];
        b_s = ob[j];
        cin = oc[j];
      end
      #1;
      if (g_dut[0].out_valid && !out_ready) begin
        if (stall_left == 3) begin
          held = got16();
        end else begin
          n_cmp++;
          if (got16() !== held) begin
            n_bad++;
            $display("FAIL bp_stable: got %h, required %h", got16(), held);
          end
        end
        n_cmp++;
        if (g_dut[0].in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_in_ready: got %b, required 0", g_dut[0].in_ready);
        end
      end
      if (was_stall && out_ready) begin
        n_cmp++;
        if (g_dut[0].in_ready !== 1'b1 || in_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_release: got in_ready=%b in_valid=%b, required 1 1",
                   g_dut[0].in_ready, in_valid);
        end
      end
      if (g_dut[0].out_valid && out_ready) begin
        n_cmp++;
        if (exq.size() == 0) begin
          n_bad++;
          $display("FAIL bp_dup: got result %h, required none pending", got16());
        end else begin
          e = exq.pop_front();
          if (got16() !== e) begin
            n_bad++;
            $display("FAIL bp_value #%0d: got %h, required %h", ret, got16(), e);
          end
        end
        ret++;
      end
      if (in_valid && g_dut[0].in_ready) begin
        exq.push_back(model(16, a_s, b_s, cin));
        j++;
      end
      was_stall = !out_ready;
      if (stall_left > 0) stall_left--;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (ret !== 10 || exq.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d retired %0d pending, required 10 retired 0 pending",
               ret, exq.size());
    end
  endtask

  task automatic test_sweep();
    bit take = 1;
    idle(3);
    for (int t = 0; t < 1600; t++) begin
      if (take) begin
        in_valid = ($urandom_range(7) != 0);
        a_s = ($urandom_range(15) == 0) ? 32'hFFFF_FFFF : $urandom;
        b_s = $urandom;
        cin = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      take = !in_valid || g_dut[0].in_ready;
      step();
    end
    idle(40);
  endtask

  task automatic test_drain();
    int pend [NI];
    pend[0] = g_dut[0].q.size();
    pend[1] = g_dut[1].q.size();
    pend[2] = g_dut[2].q.size();
    pend[3] = g_dut[3].q.size();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (pend[i] !== 0) begin
        n_bad++;
        $display("FAIL drain W=%0d C=%0d: got %0d pending, required 0", WS[i], CS[i], pend[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_sweep();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
